motor_pattern_decoder: RTL and testbench

- Receive end of the motor-drive interface. Each of the 4 motor lines carries its 8-bit speed pattern serially, MSB first, one bit per clock.
- Deserialises one frame per motor line and classifies each pattern. Recovers the active motor index and speed level (0-3), and flags illegal frames.
- Sits on the feedback/monitor path beside the motor controller and feeds status logic.

---
 rtl/motor_pkg.sv | 38 +++
 rtl/motor_pattern_decoder_classify.sv | 19 +
 rtl/motor_pattern_decoder.sv | 142 ++++++++++++++
 tb/tb_motor_pattern_decoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared motor-drive definitions: speed codes, level type, lane classes
// and decoder FSM states.
package motor_pkg;

    localparam int FRAME_LEN = 8;

    // Same codes the motor controller serialises onto each line
    localparam logic [FRAME_LEN-1:0] CODE_L1 = 8'b0000_1111;
    localparam logic [FRAME_LEN-1:0] CODE_L2 = 8'b0011_0011;
    localparam logic [FRAME_LEN-1:0] CODE_L3 = 8'b1100_0011;

    typedef logic [1:0] level_t;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_L1,
        CLS_L2,
        CLS_L3,
        CLS_BAD
    } lane_class_t;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    function automatic level_t class_to_level(input lane_class_t c);
        level_t lvl;
        case (c)
            CLS_L1:  lvl = 2'd1;
            CLS_L2:  lvl = 2'd2;
            CLS_L3:  lvl = 2'd3;
            default: lvl = 2'd0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/motor_pattern_decoder_classify.sv
// Combinational classifier: one 8-bit lane pattern to its lane class.
module motor_code_classify
    import motor_pkg::*;
(
    input  logic [FRAME_LEN-1:0] pattern_i,
    output lane_class_t          class_o
);

    always_comb begin
        case (pattern_i)
            8'h00:   class_o = CLS_ZERO;
            CODE_L1: class_o = CLS_L1;
            CODE_L2: class_o = CLS_L2;
            CODE_L3: class_o = CLS_L3;
            default: class_o = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/motor_pattern_decoder.sv
// Four-lane serial speed-pattern receiver: deserialises, classifies and
// reports the active motor, its speed level and frame errors.
module motor_pattern_decoder
    import motor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic [3:0] line_in,
    output logic [1:0] sel,
    output level_t     level,
    output logic       valid,
    output logic       err,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam logic [2:0] CNT_INIT = 3'(FRAME_LEN - 2);

    state_t               state_q;
    logic [FRAME_LEN-1:0] sr_q [4];
    logic [2:0]           bit_cnt_q;
    logic                 pending_q;
    logic [1:0]           sel_q;
    level_t               level_q;
    logic                 valid_q;
    logic                 err_q;
    logic [7:0]           err_cnt_q;

    lane_class_t cls [4];

    for (genvar g = 0; g < 4; g++) begin : g_lane
        motor_code_classify u_cls (
            .pattern_i (sr_q[g]),
            .class_o   (cls[g])
        );
    end

    logic [2:0] nz_cnt;
    logic       any_bad;
    logic [1:0] hit_idx;
    level_t     hit_lvl;
    logic       dec_good;
    logic       abort;
    logic       valid_d;
    logic       err_d;
    logic [7:0] err_cnt_d;

    always_comb begin
        nz_cnt  = 3'd0;
        any_bad = 1'b0;
        hit_idx = 2'd0;
        hit_lvl = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (cls[i] == CLS_BAD) begin
                any_bad = 1'b1;
            end
            if (cls[i] != CLS_ZERO) begin
                nz_cnt  = nz_cnt + 3'd1;
                hit_idx = 2'(i);
                hit_lvl = class_to_level(cls[i]);
            end
        end
    end

    // A stop frame (no lane active) is good but leaves sel alone
    assign dec_good  = !any_bad && (nz_cnt <= 3'd1);
    assign abort     = (state_q == ST_SHIFT) && frame_start;
    assign valid_d   = pending_q && dec_good;
    assign err_d     = (pending_q && !dec_good) || abort;
    assign err_cnt_d = (err_d && (err_cnt_q != 8'hFF))
                     ? err_cnt_q + 8'd1 : err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            pending_q <= 1'b0;
            sel_q     <= 2'd0;
            level_q   <= 2'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            pending_q <= 1'b0;

            if (valid_d) begin
                level_q <= hit_lvl;
                if (nz_cnt == 3'd1) begin
                    sel_q <= hit_idx;
                end
            end

            // Decode above reads pre-edge shift contents, so a new
            // frame may be captured on the same edge.
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q   <= ST_SHIFT;
                        bit_cnt_q <= CNT_INIT;
                        for (int i = 0; i < 4; i++) begin
                            sr_q[i] <= {{(FRAME_LEN-1){1'b0}}, line_in[i]};
                        end
                    end
                end
                ST_SHIFT: begin
                    if (frame_start) begin
                        bit_cnt_q <= CNT_INIT;
                        for (int i = 0; i < 4; i++) begin
                            sr_q[i] <= {{(FRAME_LEN-1){1'b0}}, line_in[i]};
                        end
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            sr_q[i] <= {sr_q[i][FRAME_LEN-2:0], line_in[i]};
                        end
                        if (bit_cnt_q == 3'd0) begin
                            state_q   <= ST_IDLE;
                            pending_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sel     = sel_q;
    assign level   = level_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign busy    = (state_q == ST_SHIFT);
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_motor_pattern_decoder.sv
// Directed self-checking bench for motor_pattern_decoder.
module tb_motor_pattern_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic [3:0] line_in;
    logic [1:0] sel;
    logic [1:0] level;
    logic       valid;
    logic       err;
    logic       busy;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    motor_pattern_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .line_in     (line_in),
        .sel         (sel),
        .level       (level),
        .valid       (valid),
        .err         (err),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // f packs lanes as {lane3, lane2, lane1, lane0}
    task automatic set_bits(input logic fs, input logic [31:0] f, input int b);
        frame_start = fs;
        for (int i = 0; i < 4; i++) begin
            line_in[i] = f[i*8 + b];
        end
    endtask

    task automatic go_idle;
        frame_start = 1'b0;
        line_in     = 4'h0;
    endtask

    // Drives E0..E7; returns #1 after E7
    task automatic send_frame(input logic [31:0] f);
        for (int b = 7; b >= 0; b--) begin
            set_bits(b == 7, f, b);
            tick();
        end
        go_idle();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        go_idle();
        tick();
        tick();
        checks++;
        if ({sel, level, valid, err, busy, err_cnt} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {sel, level, valid, err, busy, err_cnt});
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if ({valid, err, busy} !== 3'b000) begin
                failures++;
                $display("FAIL idle_quiet cyc=%0d got=%b exp=000", c, {valid, err, busy});
            end
        end
    endtask

    task automatic test_single;
        send_frame({8'h00, 8'h33, 8'h00, 8'h00});
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_e7 valid=%b busy=%b exp=0,0", valid, busy);
        end
        tick();
        checks++;
        if ({valid, err, sel, level} !== {1'b1, 1'b0, 2'd2, 2'd2}) begin
            failures++;
            $display("FAIL single_decode got v=%b e=%b sel=%0d lvl=%0d exp v=1 e=0 sel=2 lvl=2",
                     valid, err, sel, level);
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse_width got=%b exp=0", valid);
        end
    endtask

    task automatic test_stop;
        send_frame({8'h00, 8'h00, 8'hC3, 8'h00});
        tick();
        checks++;
        if ({valid, sel, level} !== {1'b1, 2'd1, 2'd3}) begin
            failures++;
            $display("FAIL l3_lane1 got v=%b sel=%0d lvl=%0d exp v=1 sel=1 lvl=3",
                     valid, sel, level);
        end
        send_frame(32'h0);
        tick();
        checks++;
        if ({valid, err, sel, level} !== {1'b1, 1'b0, 2'd1, 2'd0}) begin
            failures++;
            $display("FAIL stop_frame got v=%b e=%b sel=%0d lvl=%0d exp v=1 e=0 sel=1 lvl=0",
                     valid, err, sel, level);
        end
        tick();
    endtask

    task automatic test_errors;
        send_frame({8'hC3, 8'h00, 8'h00, 8'h0F});
        tick();
        checks++;
        if ({err, valid, sel, level, err_cnt} !== {1'b1, 1'b0, 2'd1, 2'd0, 8'd1}) begin
            failures++;
            $display("FAIL two_lanes got e=%b v=%b sel=%0d lvl=%0d cnt=%0d exp e=1 v=0 sel=1 lvl=0 cnt=1",
                     err, valid, sel, level, err_cnt);
        end
        tick();
        send_frame({8'h00, 8'h00, 8'hA5, 8'h00});
        tick();
        checks++;
        if ({err, valid, err_cnt} !== {1'b1, 1'b0, 8'd2}) begin
            failures++;
            $display("FAIL bad_code got e=%b v=%b cnt=%0d exp e=1 v=0 cnt=2",
                     err, valid, err_cnt);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] fr [4];
        int exp_lvl [4];
        int pulses;
        fr[0] = {24'h0, 8'h0F};
        fr[1] = {16'h0, 8'h33, 8'h00};
        fr[2] = {8'h00, 8'hC3, 16'h0};
        fr[3] = {8'h0F, 24'h0};
        exp_lvl = '{1, 2, 3, 1};
        pulses = 0;
        for (int f = 0; f < 4; f++) begin
            for (int b = 7; b >= 0; b--) begin
                set_bits(b == 7, fr[f], b);
                tick();
                if (valid === 1'b1) pulses++;
                if (b == 7 && f > 0) begin
                    checks++;
                    if ({valid, sel, level} !== {1'b1, 2'(f - 1), 2'(exp_lvl[f-1])}) begin
                        failures++;
                        $display("FAIL b2b_frame%0d got v=%b sel=%0d lvl=%0d exp v=1 sel=%0d lvl=%0d",
                                 f - 1, valid, sel, level, f - 1, exp_lvl[f-1]);
                    end
                end
            end
        end
        go_idle();
        tick();
        if (valid === 1'b1) pulses++;
        checks++;
        if ({valid, sel, level} !== {1'b1, 2'd3, 2'd1}) begin
            failures++;
            $display("FAIL b2b_frame3 got v=%b sel=%0d lvl=%0d exp v=1 sel=3 lvl=1",
                     valid, sel, level);
        end
        tick();
        checks++;
        if (pulses !== 4) begin
            failures++;
            $display("FAIL b2b_pulses got=%0d exp=4", pulses);
        end
    endtask

    task automatic test_abort;
        logic [31:0] fa;
        logic [31:0] fb;
        fa = {24'h0, 8'h33};
        fb = {8'hC3, 24'h0};
        for (int b = 7; b >= 4; b--) begin
            set_bits(b == 7, fa, b);
            tick();
        end
        set_bits(1'b1, fb, 7);
        tick();
        checks++;
        if ({err, valid, busy, err_cnt} !== {1'b1, 1'b0, 1'b1, 8'd3}) begin
            failures++;
            $display("FAIL abort_err got e=%b v=%b busy=%b cnt=%0d exp e=1 v=0 busy=1 cnt=3",
                     err, valid, busy, err_cnt);
        end
        for (int b = 6; b >= 0; b--) begin
            set_bits(1'b0, fb, b);
            tick();
        end
        go_idle();
        tick();
        checks++;
        if ({valid, err, sel, level} !== {1'b1, 1'b0, 2'd3, 2'd3}) begin
            failures++;
            $display("FAIL abort_next got v=%b e=%b sel=%0d lvl=%0d exp v=1 e=0 sel=3 lvl=3",
                     valid, err, sel, level);
        end
        tick();
    endtask

    task automatic test_reset_midframe;
        logic [31:0] f;
        f = {24'h0, 8'h0F};
        for (int b = 7; b >= 5; b--) begin
            set_bits(b == 7, f, b);
            tick();
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({sel, level, valid, err, busy, err_cnt} !== 15'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0",
                     {sel, level, valid, err, busy, err_cnt});
        end
        set_bits(1'b0, f, 4);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) set_bits(1'b0, f, 3 - c);
            else go_idle();
            tick();
            checks++;
            if ({valid, err, busy} !== 3'b000) begin
                failures++;
                $display("FAIL after_reset cyc=%0d got=%b exp=000", c, {valid, err, busy});
            end
        end
    endtask

    task automatic test_saturation;
        logic [31:0] f;
        int pulses;
        f = {16'h0, 8'hA5, 8'h00};
        pulses = 0;
        for (int n = 0; n < 260; n++) begin
            for (int b = 7; b >= 0; b--) begin
                set_bits(b == 7, f, b);
                tick();
                if (err === 1'b1) pulses++;
            end
        end
        go_idle();
        tick();
        if (err === 1'b1) pulses++;
        checks++;
        if ({err, err_cnt} !== {1'b1, 8'd255}) begin
            failures++;
            $display("FAIL saturate got e=%b cnt=%0d exp e=1 cnt=255", err, err_cnt);
        end
        checks++;
        if (pulses !== 260) begin
            failures++;
            $display("FAIL sat_pulses got=%0d exp=260", pulses);
        end
        tick();
        checks++;
        if (err_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_hold got=%0d exp=255", err_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        line_in = 4'h0;
        test_reset();
        test_single();
        test_stop();
        test_errors();
        test_back_to_back();
        test_abort();
        test_reset_midframe();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
